// File: rtl/serial_add_arbiter_if.sv
// Request/result bundle between parallel operand sources and the shared serial adder.
// SERIAL_ADD_ARB_SUB_EN adds the per-requester subtract select.
interface serial_add_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
`ifdef SERIAL_ADD_ARB_SUB_EN
  logic [NREQ-1:0]       sub;
`endif
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [ID_W-1:0]       done_id;
  logic [WIDTH-1:0]      sum;
  logic                  cout;

`ifdef SERIAL_ADD_ARB_SUB_EN
  modport master (output req, a_in, b_in, sub,
                  input  gnt, busy, done, done_id, sum, cout);
  modport slave  (input  req, a_in, b_in, sub,
                  output gnt, busy, done, done_id, sum, cout);
`else
  modport master (output req, a_in, b_in,
                  input  gnt, busy, done, done_id, sum, cout);
  modport slave  (input  req, a_in, b_in,
                  output gnt, busy, done, done_id, sum, cout);
`endif
endinterface

// File: rtl/serial_add_arbiter.sv
// Round-robin shared bit-serial adder: one full adder + carry flop serves NREQ sources.
// Optional macro SERIAL_ADD_ARB_SUB_EN enables per-request A-B via inverted B and carry-in 1.
module serial_add_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_add_arbiter_if.slave  bus
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   ptr_q, id_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q;
  logic              carry_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NREQ-1:0]   gnt_q;
  logic              busy_q, done_q, cout_q;
  logic [ID_W-1:0]   done_id_q;
  logic [WIDTH-1:0]  sum_q;

  logic [ID_W-1:0]   win_idx;
  logic              win_vld;
  logic              sub_q, cin_d;
  logic              b_bit, sum_bit, carry_d;
  logic [WIDTH-1:0]  res_d;

`ifdef SERIAL_ADD_ARB_SUB_EN
  logic sub_d;
  assign sub_d = bus.sub[win_idx];
  assign cin_d = sub_d;
`else
  assign sub_q = 1'b0;
  assign cin_d = 1'b0;
`endif

  // Scan downward so the candidate closest to the pointer is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req[idx]) begin
        win_vld = 1'b1;
        win_idx = ID_W'(idx);
      end
    end
  end

  always_comb begin
    b_bit   = b_q[0] ^ sub_q;
    sum_bit = a_q[0] ^ b_bit ^ carry_q;
    carry_d = (a_q[0] & b_bit) | (a_q[0] & carry_q) | (b_bit & carry_q);
    res_d   = {sum_bit, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
`ifdef SERIAL_ADD_ARB_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            a_q     <= bus.a_in[win_idx*WIDTH +: WIDTH];
            b_q     <= bus.b_in[win_idx*WIDTH +: WIDTH];
            carry_q <= cin_d;
`ifdef SERIAL_ADD_ARB_SUB_EN
            sub_q   <= sub_d;
`endif
            gnt_q   <= NREQ'(1) << win_idx;
            id_q    <= win_idx;
            ptr_q   <= (win_idx == ID_W'(NREQ-1)) ? '0 : win_idx + ID_W'(1);
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          gnt_q   <= '0;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          // Last shift: publish the result on the same edge that completes it.
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            done_q    <= 1'b1;
            sum_q     <= res_d;
            cout_q    <= carry_d;
            done_id_q <= id_q;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: directed scenarios plus randomized traffic against
// an arithmetic/round-robin reference model.
module tb_serial_add_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_add_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
  serial_add_arbiter #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int ptr_m = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-robin reference: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  // {cout, sum} from plain arithmetic; subtract is A + ~B + 1.
  function automatic logic [W:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    logic [W:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in[i*W +: W] = a;
    bus.b_in[i*W +: W] = b;
    bus.req[i] = 1'b1;
  endtask

  task automatic wait_gnt(output int id, output logic [N-1:0] g, output int waited, output bit ok);
    ok = 0; id = -1; g = '0; waited = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        ok = 1; waited = c; g = bus.gnt;
        for (int j = N-1; j >= 0; j--) if (g[j]) id = j;
        return;
      end
    end
  endtask

  task automatic wait_done(output logic [W-1:0] s, output logic c, output int id,
                           output int lat, output bit ok, output int gnt_seen);
    ok = 0; s = '0; c = 1'b0; id = -1; lat = 0; gnt_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) gnt_seen++;
      if (bus.done) begin
        ok = 1; lat = k; s = bus.sum; c = bus.cout; id = int'(bus.done_id);
        return;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.req = '0; bus.a_in = '0; bus.b_in = '0;
`ifdef SERIAL_ADD_ARB_SUB_EN
    bus.sub = '0;
`endif
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.gnt !== '0)  begin n_bad++; $display("FAIL reset_gnt got %h want 0", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if ({bus.sum, bus.cout, bus.done_id} !== '0)
      begin n_bad++; $display("FAIL reset_result got sum=%h cout=%b id=%0d want 0", bus.sum, bus.cout, bus.done_id); end
    reset = 1'b1;
    ptr_m = 0;
    @(negedge clk);
  endtask

  task automatic test_single_add;
    int id, waited, lat, did, gs; logic [N-1:0] g; bit ok; logic [W-1:0] s; logic c;
    issue(0, 8'h3C, 8'h05);
    wait_gnt(id, g, waited, ok);
    bus.req[0] = 1'b0;
    n_cmp++; if (!ok || g !== 4'b0001 || waited != 1)
      begin n_bad++; $display("FAIL single_gnt got %b after %0d want 0001 after 1", g, waited); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", bus.busy); end
    ptr_m = 1;
    wait_done(s, c, did, lat, ok, gs);
    n_cmp++; if (!ok || lat != W) begin n_bad++; $display("FAIL single_latency got %0d want %0d", lat, W); end
    n_cmp++; if (gs != 0) begin n_bad++; $display("FAIL single_gnt_width extra gnt cycles %0d want 0", gs); end
    n_cmp++; if (s !== 8'h41 || c !== 1'b0 || did != 0)
      begin n_bad++; $display("FAIL single_result got sum=%h cout=%b id=%0d want 41 0 0", s, c, did); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      begin n_bad++; $display("FAIL single_after got done=%b busy=%b want 0 0", bus.done, bus.busy); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.sum !== 8'h41 || bus.done !== 1'b0 || bus.gnt !== '0)
      begin n_bad++; $display("FAIL idle_hold got sum=%h done=%b gnt=%b want 41 0 0", bus.sum, bus.done, bus.gnt); end
  endtask

  task automatic test_overflow;
    int id, waited, lat, did, gs; logic [N-1:0] g; bit ok; logic [W-1:0] s; logic c;
    issue(2, 8'hFF, 8'h01);
    wait_gnt(id, g, waited, ok);
    bus.req[2] = 1'b0;
    n_cmp++; if (!ok || id != 2) begin n_bad++; $display("FAIL overflow_gnt got %0d want 2", id); end
    ptr_m = 3;
    wait_done(s, c, did, lat, ok, gs);
    n_cmp++; if (!ok || s !== 8'h00 || c !== 1'b1 || did != 2)
      begin n_bad++; $display("FAIL overflow_result got sum=%h cout=%b id=%0d want 00 1 2", s, c, did); end
  endtask

  task automatic test_rotation;
    int id, waited, lat, did, gs, exp_id; logic [N-1:0] g; bit ok; logic [W-1:0] s; logic c; logic [W:0] e;
    issue(0, 8'h11, 8'h22);
    issue(3, 8'h80, 8'h90);
    for (int k = 0; k < 2; k++) begin
      exp_id = model_pick(bus.req);
      wait_gnt(id, g, waited, ok);
      n_cmp++; if (!ok || id != exp_id || id != (k == 0 ? 3 : 0))
        begin n_bad++; $display("FAIL rotation_order step %0d got %0d want %0d", k, id, exp_id); end
      if (id < 0) return;
      e = model_op(bus.a_in[id*W +: W], bus.b_in[id*W +: W], 1'b0);
      bus.req[id] = 1'b0;
      ptr_m = (id + 1) % N;
      wait_done(s, c, did, lat, ok, gs);
      n_cmp++; if (!ok || {c, s} !== e || did != id)
        begin n_bad++; $display("FAIL rotation_result got %h id=%0d want %h id=%0d", {c, s}, did, e, id); end
    end
  endtask

  task automatic test_reset_mid;
    int id, waited, lat, did, gs, dones; logic [N-1:0] g; bit ok; logic [W-1:0] s; logic c;
    issue(1, 8'h7A, 8'h33);
    wait_gnt(id, g, waited, ok);
    bus.req[1] = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1 || bus.done !== 1'b0)
      begin n_bad++; $display("FAIL mid_inflight got busy=%b done=%b want 1 0", bus.busy, bus.done); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0 || bus.done_id !== '0)
      begin n_bad++; $display("FAIL mid_reset got busy=%b sum=%h cout=%b id=%0d want 0", bus.busy, bus.sum, bus.cout, bus.done_id); end
    reset = 1'b1;
    ptr_m = 0;
    dones = 0;
    repeat (12) begin @(negedge clk); if (bus.done) dones++; end
    n_cmp++; if (dones != 0 || bus.busy !== 1'b0)
      begin n_bad++; $display("FAIL mid_no_done got %0d dones busy=%b want 0", dones, bus.busy); end
    issue(3, 8'h01, 8'h01);
    wait_gnt(id, g, waited, ok);
    bus.req[3] = 1'b0;
    n_cmp++; if (!ok || id != model_pick(4'b1000))
      begin n_bad++; $display("FAIL mid_regrant got %0d want 3", id); end
    ptr_m = 0;
    wait_done(s, c, did, lat, ok, gs);
    n_cmp++; if (!ok || s !== 8'h02 || c !== 1'b0 || did != 3)
      begin n_bad++; $display("FAIL mid_carry_clear got sum=%h cout=%b id=%0d want 02 0 3", s, c, did); end
  endtask

  task automatic test_fairness;
    int id, waited, lat, did, gs, t_prev, t_now; logic [N-1:0] g; bit ok; logic [W-1:0] s; logic c; logic [W:0] e;
    for (int i = 0; i < N; i++) issue(i, W'($urandom), W'($urandom));
    t_prev = 0;
    for (int k = 0; k < N; k++) begin
      wait_gnt(id, g, waited, ok);
      t_now = cyc;
      n_cmp++; if (!ok || id != k || id != model_pick(bus.req) || $countones(g) != 1)
        begin n_bad++; $display("FAIL fair_order step %0d got gnt=%b want id %0d", k, g, k); end
      if (k > 0) begin
        n_cmp++; if (t_now - t_prev != W + 2)
          begin n_bad++; $display("FAIL fair_spacing got %0d want %0d", t_now - t_prev, W + 2); end
      end
      t_prev = t_now;
      if (id < 0) return;
      e = model_op(bus.a_in[id*W +: W], bus.b_in[id*W +: W], 1'b0);
      bus.req[id] = 1'b0;
      ptr_m = (id + 1) % N;
      wait_done(s, c, did, lat, ok, gs);
      n_cmp++; if (!ok || did != k || {c, s} !== e || gs != 0)
        begin n_bad++; $display("FAIL fair_done step %0d got %h id=%0d want %h id=%0d", k, {c, s}, did, e, k); end
    end
  endtask

  task automatic test_random;
    int id, waited, lat, did, gs, exp_id; logic [N-1:0] g; bit ok, sb; logic [W-1:0] s; logic c; logic [W:0] e;
    for (int it = 0; it < 40; it++) begin
      if (bus.req == '0) begin
        bus.req = N'($urandom_range(1, (1 << N) - 1));
        bus.a_in = (N*W)'({$urandom, $urandom});
        bus.b_in = (N*W)'({$urandom, $urandom});
`ifdef SERIAL_ADD_ARB_SUB_EN
        bus.sub = N'($urandom);
`endif
      end
      exp_id = model_pick(bus.req);
      wait_gnt(id, g, waited, ok);
      n_cmp++; if (!ok || id != exp_id || $countones(g) != 1)
        begin n_bad++; $display("FAIL rand_gnt iter %0d got gnt=%b want id %0d", it, g, exp_id); end
      if (id < 0) return;
      sb = 1'b0;
`ifdef SERIAL_ADD_ARB_SUB_EN
      sb = bus.sub[id];
      bus.sub[id] = ~bus.sub[id];
`endif
      e = model_op(bus.a_in[id*W +: W], bus.b_in[id*W +: W], sb);
      // Operands change after grant; the result must reflect the captured values.
      bus.a_in[id*W +: W] = W'($urandom);
      bus.b_in[id*W +: W] = W'($urandom);
      bus.req[id] = 1'b0;
      ptr_m = (id + 1) % N;
      wait_done(s, c, did, lat, ok, gs);
      n_cmp++; if (!ok || {c, s} !== e || did != id || lat != W || gs != 0)
        begin n_bad++; $display("FAIL rand_result iter %0d got %h id=%0d lat=%0d want %h id=%0d lat=%0d", it, {c, s}, did, lat, e, id, W); end
    end
  endtask

`ifdef SERIAL_ADD_ARB_SUB_EN
  task automatic test_sub;
    int id, waited, lat, did, gs; logic [N-1:0] g; bit ok; logic [W-1:0] s; logic c;
    repeat (3) @(negedge clk);
    bus.sub = '0;
    bus.sub[0] = 1'b1;
    issue(0, 8'h10, 8'h01);
    wait_gnt(id, g, waited, ok);
    bus.req[0] = 1'b0;
    wait_done(s, c, did, lat, ok, gs);
    n_cmp++; if (!ok || s !== 8'h0F || c !== 1'b1)
      begin n_bad++; $display("FAIL sub_noborrow got sum=%h cout=%b want 0F 1", s, c); end
    bus.sub[1] = 1'b1;
    issue(1, 8'h01, 8'h02);
    wait_gnt(id, g, waited, ok);
    bus.req[1] = 1'b0;
    wait_done(s, c, did, lat, ok, gs);
    n_cmp++; if (!ok || s !== 8'hFF || c !== 1'b0)
      begin n_bad++; $display("FAIL sub_borrow got sum=%h cout=%b want FF 0", s, c); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_add();
    test_overflow();
    test_rotation();
    test_reset_mid();
    test_fairness();
    test_random();
`ifdef SERIAL_ADD_ARB_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Shares one bit-serial ripple adder among `NREQ` requesters. Round-robin arbitration picks one requester, latches its two `WIDTH`-bit operands and shifts them LSB-first through a single full adder with a carry flop. It then returns the registered sum, carry-out and requester ID with a one-cycle `done` pulse. It sits between the lab's parallel operand sources and the bit-serial adder datapath, replacing per-source serial adders with one scheduled resource.

## Interface
- `WIDTH`, 8: operand and sum width; must be ≥ 2.
- `NREQ`, 4: number of requesters; must be ≥ 2.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset. Low clears all state.
- `req` input `NREQ`: per-requester request level.
- `a_in` input `NREQ*WIDTH`: operand A; requester i at bits `[i*WIDTH +: WIDTH]`.
- `b_in` input `NREQ*WIDTH`: operand B, packed the same way as `a_in`.
- `gnt` output `NREQ`: one-hot grant pulse.
- `busy` output 1: high while an operation is in flight.
- `done` output 1: one-cycle result-valid pulse.
- `done_id` output `$clog2(NREQ)`: index of the requester whose result is on `sum` and `cout`.
- `sum` output `WIDTH`: result, held until the next `done`.
- `cout` output 1: final carry, held until the next `done`.

## Operation
- FSM states are IDLE, SHIFT and DONE. Reset enters IDLE.
- Reset values:
  - `gnt` = 0, `busy` = 0, `done` = 0, `done_id` = 0, `sum` = 0, `cout` = 0.
  - Round-robin pointer = 0, carry flop = 0, bit counter = 0.
- IDLE with `req` ≠ 0:
  - Winner is the first set `req` bit searching upward from the pointer, wrapping from `NREQ-1` to 0.
  - Latch the winner's A and B into shift registers and set the carry flop to the carry-in (0).
  - Pulse `gnt[winner]`, record the winner ID, set the pointer to winner+1 modulo `NREQ`, and go to SHIFT.
- IDLE with `req` = 0: remain in IDLE; all outputs hold.
- SHIFT, each cycle:
  - Full-add the operand LSBs with the carry flop.
  - Shift the sum bit into the result register MSB-first, so that after `WIDTH` shifts bit 0 is in position 0.
  - Right-shift both operands, update the carry flop and increment the counter.
  - After the `WIDTH`-th shift, go to DONE.
- DONE:
  - `done` = 1; `sum`, `cout` and `done_id` update on the same edge.
  - Next state is IDLE.
- Requesters keep `req` high until they see their `gnt`, then drop it the following cycle. A `req` still high when IDLE is re-entered counts as a new request.
- Operands are captured only at grant. Changes to `a_in` or `b_in` afterwards do not affect the result.
- `req` changes during SHIFT or DONE are ignored until IDLE. There is no pre-emption.
- Arithmetic is modulo 2^`WIDTH`. `cout` is the carry out of bit `WIDTH-1`.
- Reset asserted mid-operation aborts the operation:
  - No `done` is produced.
  - `sum`, `cout` and `done_id` return to 0.
  - The pointer returns to 0.

## Timing
- Grant edge E0 (IDLE, `req` seen): `gnt` and `busy` go high after E0.
- `gnt` is high for exactly one cycle and clears at E1.
- Edges E1..E`WIDTH` perform the shifts. `done`, `sum`, `cout` and `done_id` are valid after E`WIDTH`.
- `done` clears and `busy` falls after E`WIDTH`+1.
- The earliest next grant is at E`WIDTH`+2. Back-to-back throughput is one operation per `WIDTH`+2 cycles (10 cycles for `WIDTH`=8).
- Latency from the `req`-sampling edge to `done` visible is `WIDTH` cycles after the grant edge.
- `done` and `gnt` are never high in the same cycle.

## Configuration
- Macro: `SERIAL_ADD_ARB_SUB_EN`.
- Defined:
  - Adds input `sub` (width `NREQ`), latched with the operands at grant.
  - If the latched `sub` = 1, B is inverted bit-wise as it is shifted and the carry flop initialises to 1, giving A − B.
  - `cout` = 1 means no borrow.
- Undefined: the `sub` port is absent, the carry-in is always 0, and the operation is always A + B.

## Test plan
- Single add:
  - Stimulus: after reset release, `req` = 0001 with A0 = 0x3C, B0 = 0x05.
  - Response: `gnt` = 0001 for one cycle; 8 cycles after the grant edge, `done` = 1 with `sum` = 0x41, `cout` = 0, `done_id` = 0.
- Overflow:
  - Stimulus: requester 2, A = 0xFF, B = 0x01.
  - Response: `sum` = 0x00, `cout` = 1, `done_id` = 2.
- Fairness:
  - Stimulus: `req` = 1111 held continuously, each requester dropping its `req` after its grant.
  - Response: grants occur in order 0, 1, 2, 3, spaced 10 cycles apart; `done_id` follows the same order; `gnt` is never multi-hot.
- Rotation:
  - Stimulus: after a grant to 2, raise `req` = 1001.
  - Response: requester 3 is granted first, then requester 0.
- Reset mid-SHIFT:
  - Stimulus: after the 4th shift, pulse `reset` low for 1 cycle.
  - Response: `busy` = 0, `sum` = 0, and no `done`. A following request with A = 0x01, B = 0x01 yields `sum` = 0x02, `cout` = 0, showing the carry was cleared.
- With `SERIAL_ADD_ARB_SUB_EN`:
  - 0x10 − 0x01 gives 0x0F, `cout` = 1.
  - 0x01 − 0x02 gives 0xFF, `cout` = 0.
